// File: rtl/nibble_ctrl.sv
// nibble_ctrl: fetch/decode/execute controller for the Nibbler 4-bit CPU.
// Owns PC and IR, reads the synchronous program ROM and drives the
// accumulator, flag-register and output-port write strobes.
module nibble_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rom_data,
  input  logic       c_flag,
  input  logic       z_flag,
  output logic [7:0] rom_addr,
  output logic [3:0] operand,
  output logic [1:0] alu_op,
  output logic       alu_src,
  output logic       acc_load,
  output logic       flag_load,
  output logic       out_load,
  output logic       halted
);

  typedef enum logic [2:0] {
    S_F0  = 3'd0,
    S_F1  = 3'd1,
    S_EX  = 3'd2,
    S_J0  = 3'd3,
    S_J1  = 3'd4,
    S_HLT = 3'd5
  } state_t;

  localparam logic [3:0] OP_LIT   = 4'h1;
  localparam logic [3:0] OP_ADDI  = 4'h2;
  localparam logic [3:0] OP_SUBI  = 4'h3;
  localparam logic [3:0] OP_NANDI = 4'h4;
  localparam logic [3:0] OP_OUT   = 4'h5;
  localparam logic [3:0] OP_IN    = 4'h6;
  localparam logic [3:0] OP_JMP   = 4'h7;
  localparam logic [3:0] OP_JC    = 4'h8;
  localparam logic [3:0] OP_JZ    = 4'h9;
  localparam logic [3:0] OP_HALT  = 4'hF;

  state_t     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] ir_q, ir_d;
  logic [3:0] opcode;
  logic       is_jump;
  logic       jump_taken;

  assign opcode  = ir_q[7:4];
  assign is_jump = (opcode == OP_JMP) || (opcode == OP_JC) || (opcode == OP_JZ);

  // Flags only feed the J1 PC select, never an output.
  always_comb begin
    jump_taken = 1'b0;
    case (opcode)
      OP_JMP:  jump_taken = 1'b1;
      OP_JC:   jump_taken = c_flag;
      OP_JZ:   jump_taken = z_flag;
      default: jump_taken = 1'b0;
    endcase
  end

  // State, PC and IR registers; reset returns to a fetch from 0x00.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_F0;
      pc_q    <= 8'h00;
      ir_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  // Next-state sequencing; PC increments wrap modulo 256 naturally.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      S_F0: state_d = S_F1;
      S_F1: begin
        ir_d    = rom_data;
        pc_d    = pc_q + 8'd1;
        state_d = S_EX;
      end
      S_EX: begin
        if (opcode == OP_HALT) state_d = S_HLT;
        else if (is_jump)      state_d = S_J0;
        else                   state_d = S_F0;
      end
      S_J0: state_d = S_J1;
      S_J1: begin
        pc_d    = jump_taken ? rom_data : (pc_q + 8'd1);
        state_d = S_F0;
      end
      S_HLT:   state_d = S_HLT;
      default: state_d = S_F0;
    endcase
  end

  // Output decode from registered state and IR only.
  always_comb begin
    acc_load  = 1'b0;
    flag_load = 1'b0;
    out_load  = 1'b0;
    alu_src   = (opcode == OP_IN);
    case (opcode)
      OP_ADDI:  alu_op = 2'b01;
      OP_SUBI:  alu_op = 2'b10;
      OP_NANDI: alu_op = 2'b11;
      default:  alu_op = 2'b00;
    endcase
    if (state_q == S_EX) begin
      case (opcode)
        OP_LIT, OP_IN: acc_load = 1'b1;
        OP_ADDI, OP_SUBI, OP_NANDI: begin
          acc_load  = 1'b1;
          flag_load = 1'b1;
        end
        OP_OUT:  out_load = 1'b1;
        default: ;
      endcase
    end
  end

  assign rom_addr = pc_q;
  assign operand  = ir_q[3:0];
  assign halted   = (state_q == S_HLT);

endmodule

// File: tb/tb_nibble_ctrl.sv
// Bench for nibble_ctrl: behavioural ROM plus a per-cycle scoreboard of
// expected addresses and strobes derived from the instruction timing.
module tb_nibble_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rom_data = 8'h00;
  logic       c_flag = 1'b0;
  logic       z_flag = 1'b0;
  logic [7:0] rom_addr;
  logic [3:0] operand;
  logic [1:0] alu_op;
  logic       alu_src, acc_load, flag_load, out_load, halted;

  int errors = 0;
  int checks = 0;

  logic [7:0] rom [256];

  typedef struct packed {
    logic [7:0] a;
    logic       acc, flg, out, hlt, src;
    logic [1:0] op;
    logic [3:0] nib;
  } exp_t;

  exp_t sb[$];
  exp_t obs;

  nibble_ctrl dut (
    .clk(clk), .reset(reset), .rom_data(rom_data), .c_flag(c_flag), .z_flag(z_flag),
    .rom_addr(rom_addr), .operand(operand), .alu_op(alu_op), .alu_src(alu_src),
    .acc_load(acc_load), .flag_load(flag_load), .out_load(out_load), .halted(halted)
  );

  always #5 clk = ~clk;

  // Synchronous ROM, one cycle of latency.
  always @(posedge clk) rom_data <= rom[rom_addr];

  assign obs = '{a: rom_addr, acc: acc_load, flg: flag_load, out: out_load,
                 hlt: halted, src: alu_src, op: alu_op, nib: operand};

  // ALU select fields are only meaningful while acc_load is high.
  function automatic exp_t msk(exp_t e);
    exp_t m;
    m = '1;
    if (!e.acc) begin
      m.src = 1'b0;
      m.op  = 2'b00;
      m.nib = 4'h0;
    end
    return m;
  endfunction

  function automatic void push(logic [7:0] a, logic acc, logic flg, logic out, logic hlt,
                               logic src, logic [1:0] op, logic [3:0] nib);
    exp_t e;
    e = '{a: a, acc: acc, flg: flg, out: out, hlt: hlt, src: src, op: op, nib: nib};
    sb.push_back(e);
  endfunction

  function automatic void idle(logic [7:0] a, logic hlt);
    push(a, 1'b0, 1'b0, 1'b0, hlt, 1'b0, 2'b00, 4'h0);
  endfunction

  task automatic fill_rom();
    for (int i = 0; i < 256; i++) rom[i] = 8'hF0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    fill_rom();
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    checks++; if (rom_addr !== 8'h00) begin errors++; $display("FAIL reset_addr got=%h want=00", rom_addr); end
    checks++; if (operand !== 4'h0) begin errors++; $display("FAIL reset_operand got=%h want=0", operand); end
    checks++; if (alu_op !== 2'b00 || alu_src !== 1'b0) begin errors++; $display("FAIL reset_alu got=%b/%b want=00/0", alu_op, alu_src); end
    checks++; if ({acc_load, flag_load, out_load, halted} !== 4'b0000) begin
      errors++; $display("FAIL reset_strobes got=%b want=0000", {acc_load, flag_load, out_load, halted});
    end
  endtask

  task automatic test_lit_out();
    exp_t e, m;
    int cyc = 0;
    fill_rom();
    rom[0] = 8'h15; rom[1] = 8'h50;
    do_reset();
    idle(8'h00, 0); idle(8'h00, 0); push(8'h01, 1, 0, 0, 0, 0, 2'b00, 4'h5);
    idle(8'h01, 0); idle(8'h01, 0); push(8'h02, 0, 0, 1, 0, 0, 2'b00, 4'h0);
    idle(8'h02, 0); idle(8'h02, 0); idle(8'h03, 0); idle(8'h03, 1);
    while (sb.size() > 0) begin
      e = sb.pop_front(); @(negedge clk); cyc++; m = msk(e);
      checks++;
      if ((obs & m) !== (e & m)) begin errors++; $display("FAIL lit_out cyc%0d got=%h want=%h", cyc, obs & m, e & m); end
    end
  endtask

  task automatic test_alu_ops();
    exp_t e, m;
    int cyc = 0;
    fill_rom();
    rom[0] = 8'h23; rom[1] = 8'h37; rom[2] = 8'h4A; rom[3] = 8'h60;
    do_reset();
    idle(8'h00, 0); idle(8'h00, 0); push(8'h01, 1, 1, 0, 0, 0, 2'b01, 4'h3);
    idle(8'h01, 0); idle(8'h01, 0); push(8'h02, 1, 1, 0, 0, 0, 2'b10, 4'h7);
    idle(8'h02, 0); idle(8'h02, 0); push(8'h03, 1, 1, 0, 0, 0, 2'b11, 4'hA);
    idle(8'h03, 0); idle(8'h03, 0); push(8'h04, 1, 0, 0, 0, 1, 2'b00, 4'h0);
    idle(8'h04, 0); idle(8'h04, 0); idle(8'h05, 0); idle(8'h05, 1);
    while (sb.size() > 0) begin
      e = sb.pop_front(); @(negedge clk); cyc++; m = msk(e);
      checks++;
      if ((obs & m) !== (e & m)) begin errors++; $display("FAIL alu_ops cyc%0d got=%h want=%h", cyc, obs & m, e & m); end
    end
  endtask

  task automatic test_jumps();
    exp_t e, m;
    logic [7:0] opc [6] = '{8'h80, 8'h80, 8'h90, 8'h90, 8'h73, 8'h8F};
    logic       cf  [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic       zf  [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic       tk  [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [7:0] dst;
    for (int v = 0; v < 6; v++) begin
      int cyc = 0;
      fill_rom();
      rom[0] = opc[v]; rom[1] = 8'h40;
      c_flag = cf[v]; z_flag = zf[v];
      dst = tk[v] ? 8'h40 : 8'h02;
      do_reset();
      idle(8'h00, 0); idle(8'h00, 0); idle(8'h01, 0); idle(8'h01, 0); idle(8'h01, 0);
      idle(dst, 0); idle(dst, 0); idle(dst + 8'd1, 0); idle(dst + 8'd1, 1);
      while (sb.size() > 0) begin
        e = sb.pop_front(); @(negedge clk); cyc++; m = msk(e);
        checks++;
        if ((obs & m) !== (e & m)) begin errors++; $display("FAIL jump v%0d cyc%0d got=%h want=%h", v, cyc, obs & m, e & m); end
      end
    end
    c_flag = 1'b0; z_flag = 1'b0;
  endtask

  task automatic test_pc_wrap();
    exp_t e, m;
    int cyc = 0;
    // LIT at 0xFF, then fetch wraps to 0x00
    fill_rom();
    rom[0] = 8'h70; rom[1] = 8'hFF; rom[8'hFF] = 8'h10;
    do_reset();
    idle(8'h00, 0); idle(8'h00, 0); idle(8'h01, 0); idle(8'h01, 0); idle(8'h01, 0);
    idle(8'hFF, 0); idle(8'hFF, 0); push(8'h00, 1, 0, 0, 0, 0, 2'b00, 4'h0); idle(8'h00, 0);
    while (sb.size() > 0) begin
      e = sb.pop_front(); @(negedge clk); cyc++; m = msk(e);
      checks++;
      if ((obs & m) !== (e & m)) begin errors++; $display("FAIL wrap_lit cyc%0d got=%h want=%h", cyc, obs & m, e & m); end
    end
    // JMP at 0xFF reads its target byte from 0x00 (0x70)
    cyc = 0;
    fill_rom();
    rom[0] = 8'h70; rom[1] = 8'hFF; rom[8'hFF] = 8'h70;
    do_reset();
    idle(8'h00, 0); idle(8'h00, 0); idle(8'h01, 0); idle(8'h01, 0); idle(8'h01, 0);
    idle(8'hFF, 0); idle(8'hFF, 0); idle(8'h00, 0); idle(8'h00, 0); idle(8'h00, 0);
    idle(8'h70, 0); idle(8'h70, 0); idle(8'h71, 0); idle(8'h71, 1);
    while (sb.size() > 0) begin
      e = sb.pop_front(); @(negedge clk); cyc++; m = msk(e);
      checks++;
      if ((obs & m) !== (e & m)) begin errors++; $display("FAIL wrap_jmp cyc%0d got=%h want=%h", cyc, obs & m, e & m); end
    end
  endtask

  task automatic test_halt();
    exp_t e, m;
    int cyc = 0;
    fill_rom();
    rom[0] = 8'hF0; rom[1] = 8'h15;
    do_reset();
    idle(8'h00, 0); idle(8'h00, 0); idle(8'h01, 0);
    for (int i = 0; i < 20; i++) idle(8'h01, 1);
    while (sb.size() > 0) begin
      e = sb.pop_front(); @(negedge clk); cyc++; m = msk(e);
      checks++;
      if ((obs & m) !== (e & m)) begin errors++; $display("FAIL halt cyc%0d got=%h want=%h", cyc, obs & m, e & m); end
    end
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if (halted !== 1'b0 || rom_addr !== 8'h00) begin
      errors++; $display("FAIL halt_exit got=%b/%h want=0/00", halted, rom_addr);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e, m;
    for (int v = 0; v < 2; v++) begin
      int cyc = 0;
      fill_rom();
      if (v == 0) rom[0] = 8'h23;
      else begin rom[0] = 8'h70; rom[1] = 8'h40; end
      do_reset();
      idle(8'h00, 0); idle(8'h00, 0);
      if (v == 0) push(8'h01, 1, 1, 0, 0, 0, 2'b01, 4'h3);
      else begin idle(8'h01, 0); idle(8'h01, 0); end
      while (sb.size() > 0) begin
        e = sb.pop_front(); @(negedge clk); cyc++; m = msk(e);
        checks++;
        if ((obs & m) !== (e & m)) begin errors++; $display("FAIL rst_mid%0d pre cyc%0d got=%h want=%h", v, cyc, obs & m, e & m); end
      end
      // Reset lands on the edge ending EX (v=0) or J0 (v=1).
      reset = 1'b1;
      rom[0] = 8'hF0;
      @(posedge clk);
      #1 reset = 1'b0;
      cyc = 0;
      idle(8'h00, 0); idle(8'h00, 0); idle(8'h01, 0); idle(8'h01, 1); idle(8'h01, 1);
      while (sb.size() > 0) begin
        e = sb.pop_front(); @(negedge clk); cyc++; m = msk(e);
        checks++;
        if ((obs & m) !== (e & m)) begin errors++; $display("FAIL rst_mid%0d post cyc%0d got=%h want=%h", v, cyc, obs & m, e & m); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_lit_out();
    test_alu_ops();
    test_jumps();
    test_pc_wrap();
    test_halt();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nibble_ctrl.md
# nibble_ctrl

Fetch/decode/execute controller for the Nibbler 4-bit CPU. It owns the program counter and instruction register and reads program bytes from the synchronous program ROM. It drives the write side of the accumulator register: load strobe, ALU operation select, operand nibble and source select. It also drives the flag-register load strobe and the output-port strobe, and resolves conditional jumps from the flag bits.

## Interface
- No parameters. Widths fixed: 8-bit PC/ROM address, 8-bit ROM word, 4-bit datapath.
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high; sampled on rising edge of clk.
- rom_data  input  8  program ROM read data; valid the cycle after rom_addr is presented (1-cycle ROM latency).
- c_flag  input  1  carry bit from flag register.
- z_flag  input  1  zero bit from flag register.
- rom_addr  output  8  program ROM address; always equals the PC register.
- operand  output  4  equals ir[3:0], continuously.
- alu_op  output  2  00 pass operand, 01 add, 10 sub, 11 nand; decoded from ir, valid whenever acc_load is high.
- alu_src  output  1  0 = operand nibble, 1 = input port; high only for IN.
- acc_load  output  1  one-cycle pulse; accumulator captures on the edge ending the pulse.
- flag_load  output  1  one-cycle pulse; flag register captures C/Z.
- out_load  output  1  one-cycle pulse; output port captures accumulator.
- halted  output  1  high in HALT state.

## Operation
- Instruction byte: opcode = ir[7:4], immediate = ir[3:0].
- Opcodes:
  - 0 NOP.
  - 1 LIT: acc <= imm. Asserts acc_load with alu_op 00.
  - 2 ADDI: asserts acc_load and flag_load with alu_op 01.
  - 3 SUBI: asserts acc_load and flag_load with alu_op 10.
  - 4 NANDI: asserts acc_load and flag_load with alu_op 11.
  - 5 OUT: asserts out_load.
  - 6 IN: asserts acc_load with alu_src 1 and alu_op 00.
  - 7 JMP, 8 JC (taken if c_flag), 9 JZ (taken if z_flag): two-byte instructions; the second byte is the 8-bit target. ir[3:0] is ignored.
  - F HALT.
  - A–E: execute as NOP.
- States:
  - F0 (address out) -> F1.
  - F1: ir <= rom_data; pc <= pc+1 -> EX.
  - EX: non-jump: pulse strobes -> F0. Jump opcodes: no strobes -> J0. HALT -> HLT.
  - J0 (target address out) -> J1.
  - J1: pc <= rom_data if taken, else pc+1 -> F0.
  - HLT: holds pc, ir and all strobes low; exits only via reset.
- Flags are sampled in J1 only. The preceding instruction's flag_load edge has already occurred by then.
- Strobes are mutually exclusive except acc_load+flag_load together. All strobes are low in every state other than EX.
- PC arithmetic is modulo 256: 0xFF+1 = 0x00, both for fetch increment and for the operand-skip increment in J1. A jump instruction at 0xFF reads its target from 0x00.
- Reset, any state: on the sampling edge pc <= 0, ir <= 0, state <= F0. All strobes are low from that edge onward; an in-flight EX pulse is cut. A pending jump target is discarded.

## Timing
- Reset values: rom_addr 0x00, operand 0, alu_op 00, alu_src 0, acc_load 0, flag_load 0, out_load 0, halted 0.
- All outputs are registered or decoded from registered state and ir only. No combinational path from rom_data, c_flag or z_flag to any output.
- Non-jump instruction: 3 cycles (F0, F1, EX). Strobe is high in the 3rd cycle.
- Jump instruction: 5 cycles whether taken or not. rom_addr shows the new PC in the cycle after J1.
- After reset deasserts, the first F0 cycle presents address 0x00. The first acc_load can occur in cycle 3.
- halted rises in the cycle after EX of HALT.

## Test plan
- Reset, then ROM[0]=0x15 (LIT 5), ROM[1]=0x50 (OUT) -> acc_load high in cycle 3 with alu_op 00 and operand 5. out_load high in cycle 6. rom_addr sequence 0,0,1,1,1,2.
- ADDI 3 (0x23) -> single-cycle acc_load and flag_load together, alu_op 01, operand 3, out_load low.
- JC: ROM[0]=0x80, ROM[1]=0x40 with c_flag=1 -> rom_addr 0x40 in cycle 6. With c_flag=0 -> rom_addr 0x02. JZ checked the same way with z_flag.
- PC wrap: JMP to 0xFF, ROM[0xFF]=0x10 -> LIT executes, then rom_addr=0x00. A JMP placed at 0xFF fetches its target byte from 0x00.
- HALT (0xF0) -> halted=1 from the cycle after EX, rom_addr frozen, no strobes for 20 cycles. Reset then clears halted and rom_addr returns to 0x00.
- Reset asserted during EX of ADDI and during J0 of JMP -> strobes low from that edge, no jump taken, pc=0, first fetch from 0x00.
